// File: rtl/spi_arb_pkg.sv
// Shared encodings and defaults for the two-master SPI flash arbiter.
package spi_arb_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_OWN_DSP = 2'd1;
    localparam logic [1:0] ST_OWN_CPU = 2'd2;
    localparam logic [1:0] ST_GUARD   = 2'd3;

    typedef enum logic {
        OWNER_DSP = 1'b0,
        OWNER_CPU = 1'b1
    } owner_e;

    localparam int GUARD_CYCLES_DEF   = 4;
    localparam int TIMEOUT_CYCLES_DEF = 1048576;
    localparam int TMR_W_DEF          = 21;

    typedef struct packed {
        logic cs_n;
        logic sck;
        logic mosi;
    } spi_pins_t;

    // What the flash sees when nobody owns it: deselected, clock and data low.
    localparam spi_pins_t SPI_PARKED = '{cs_n: 1'b1, sck: 1'b0, mosi: 1'b0};

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser with asynchronous reset to a selectable idle value.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_flash_arbiter.sv
// Shares one SPI flash between the DSP and CPU SPI masters with a guard gap
// between owners and a hold timeout that forces the current owner off.
module spi_flash_arbiter
    import spi_arb_pkg::*;
#(
    parameter int GUARD_CYCLES   = GUARD_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int TMR_W          = TMR_W_DEF
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       dsp_bank_en,
    input  logic       dsp_cs_INV,
    input  logic       dsp_clk,
    input  logic       dsp_mosi,
    output logic       dsp_miso,
    input  logic       cpu_cs_INV,
    input  logic       cpu_clk,
    input  logic       cpu_mosi,
    output logic       cpu_miso,
    output logic       flash_cs_INV,
    output logic       flash_clk,
    output logic       flash_mosi,
    input  logic       flash_miso,
    output logic       grant_dsp,
    output logic       grant_cpu,
    output logic       timeout_flag,
    output logic [1:0] state
);

    localparam logic [3:0]       GUARD_LAST = 4'(GUARD_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMO_LAST   =
        TMR_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic             dsp_cs_s, cpu_cs_s, bank_s;
    logic             rearm_dsp, rearm_cpu;
    logic             req_dsp, req_cpu, tmr_hit;
    owner_e           last_owner;
    logic [1:0]       state_q;
    logic [3:0]       guard_cnt;
    logic [TMR_W-1:0] tmr;
    spi_pins_t        dsp_pins, cpu_pins, flash_pins;

    sync2 #(.RST_VAL(1'b1)) u_sync_dsp_cs (.clk(sysclk), .rst(reset), .d(dsp_cs_INV),  .q(dsp_cs_s));
    sync2 #(.RST_VAL(1'b1)) u_sync_cpu_cs (.clk(sysclk), .rst(reset), .d(cpu_cs_INV),  .q(cpu_cs_s));
    sync2 #(.RST_VAL(1'b0)) u_sync_bank   (.clk(sysclk), .rst(reset), .d(dsp_bank_en), .q(bank_s));

    assign req_dsp = ~dsp_cs_s & rearm_dsp & bank_s;
    assign req_cpu = ~cpu_cs_s & rearm_cpu;
    assign tmr_hit = (TIMEOUT_CYCLES != 0) && (tmr == TMO_LAST);

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_dsp    <= 1'b0;
            grant_cpu    <= 1'b0;
            timeout_flag <= 1'b0;
            last_owner   <= OWNER_CPU;
            guard_cnt    <= '0;
            tmr          <= '0;
            rearm_dsp    <= 1'b1;
            rearm_cpu    <= 1'b1;
        end else begin
            // A master that was forced off must deassert CS before it may ask again.
            if (dsp_cs_s) rearm_dsp <= 1'b1;
            if (cpu_cs_s) rearm_cpu <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    tmr       <= '0;
                    guard_cnt <= '0;
                    if (req_dsp && (!req_cpu || last_owner == OWNER_CPU)) begin
                        state_q   <= ST_OWN_DSP;
                        grant_dsp <= 1'b1;
                    end else if (req_cpu) begin
                        state_q   <= ST_OWN_CPU;
                        grant_cpu <= 1'b1;
                    end
                end
                ST_OWN_DSP: begin
                    // req_dsp already folds in the bank enable, so a bank drop
                    // releases here without touching the timeout flag.
                    if (!req_dsp || tmr_hit) begin
                        state_q    <= ST_GUARD;
                        grant_dsp  <= 1'b0;
                        last_owner <= OWNER_DSP;
                        guard_cnt  <= '0;
                        if (req_dsp) begin
                            timeout_flag <= 1'b1;
                            rearm_dsp    <= 1'b0;
                        end
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                ST_OWN_CPU: begin
                    if (!req_cpu || tmr_hit) begin
                        state_q    <= ST_GUARD;
                        grant_cpu  <= 1'b0;
                        last_owner <= OWNER_CPU;
                        guard_cnt  <= '0;
                        if (req_cpu) begin
                            timeout_flag <= 1'b1;
                            rearm_cpu    <= 1'b0;
                        end
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                default: begin
                    if (guard_cnt == GUARD_LAST) state_q   <= ST_IDLE;
                    else                         guard_cnt <= guard_cnt + 1'b1;
                end
            endcase
        end
    end

    assign dsp_pins = '{cs_n: dsp_cs_INV, sck: dsp_clk, mosi: dsp_mosi};
    assign cpu_pins = '{cs_n: cpu_cs_INV, sck: cpu_clk, mosi: cpu_mosi};

    // Pins pass straight through from the registered grant so CS release is immediate.
    always_comb begin
        flash_pins = SPI_PARKED;
        if (grant_dsp)      flash_pins = dsp_pins;
        else if (grant_cpu) flash_pins = cpu_pins;
    end

    assign flash_cs_INV = flash_pins.cs_n;
    assign flash_clk    = flash_pins.sck;
    assign flash_mosi   = flash_pins.mosi;
    assign dsp_miso     = grant_dsp ? flash_miso : 1'b1;
    assign cpu_miso     = grant_cpu ? flash_miso : 1'b1;
    assign state        = state_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed plus random bench for spi_flash_arbiter against a cycle model of the arbitration rules.
module tb_spi_flash_arbiter;

    localparam int GUARD = 4;
    localparam int TMO   = 16;

    logic sysclk = 1'b0;
    logic reset, dsp_bank_en, dsp_cs_INV, dsp_clk, dsp_mosi;
    logic cpu_cs_INV, cpu_clk, cpu_mosi, flash_miso;
    logic dsp_miso, cpu_miso, flash_cs_INV, flash_clk, flash_mosi;
    logic grant_dsp, grant_cpu, timeout_flag;
    logic [1:0] state;

    spi_flash_arbiter #(.GUARD_CYCLES(GUARD), .TIMEOUT_CYCLES(TMO), .TMR_W(21)) dut (
        .sysclk(sysclk), .reset(reset), .dsp_bank_en(dsp_bank_en),
        .dsp_cs_INV(dsp_cs_INV), .dsp_clk(dsp_clk), .dsp_mosi(dsp_mosi), .dsp_miso(dsp_miso),
        .cpu_cs_INV(cpu_cs_INV), .cpu_clk(cpu_clk), .cpu_mosi(cpu_mosi), .cpu_miso(cpu_miso),
        .flash_cs_INV(flash_cs_INV), .flash_clk(flash_clk), .flash_mosi(flash_mosi),
        .flash_miso(flash_miso), .grant_dsp(grant_dsp), .grant_cpu(grant_cpu),
        .timeout_flag(timeout_flag), .state(state)
    );

    always #100 sysclk = ~sysclk;

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0 idle, 1 DSP owns, 2 CPU owns, 3 guard gap.
    logic dd1, dd2, cd1, cd2, bd1, bd2;
    logic m_flag, m_rearm_d, m_rearm_c;
    int   m_phase, m_guard_left, m_held, m_last;

    int   first, cnt, seen;
    logic [7:0] got;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        dd1 = 1'b1; dd2 = 1'b1; cd1 = 1'b1; cd2 = 1'b1; bd1 = 1'b0; bd2 = 1'b0;
        m_flag = 1'b0; m_rearm_d = 1'b1; m_rearm_c = 1'b1;
        m_phase = 0; m_guard_left = 0; m_held = 0; m_last = 2;
    endtask

    // Each CS is seen by the arbiter two edges after it was sampled.
    task automatic model_edge();
        logic fd, fc, fb, rd, rc, nrd, nrc, req;
        fd = dd2; fc = cd2; fb = bd2;
        dd2 = dd1; dd1 = dsp_cs_INV;
        cd2 = cd1; cd1 = cpu_cs_INV;
        bd2 = bd1; bd1 = dsp_bank_en;
        rd  = !fd && m_rearm_d && fb;
        rc  = !fc && m_rearm_c;
        nrd = m_rearm_d | fd;
        nrc = m_rearm_c | fc;
        if (m_phase == 0) begin
            if (rd && rc)  m_phase = (m_last == 2) ? 1 : 2;
            else if (rd)   m_phase = 1;
            else if (rc)   m_phase = 2;
            m_held = 1;
        end else if (m_phase == 3) begin
            m_guard_left--;
            if (m_guard_left == 0) m_phase = 0;
        end else begin
            req = (m_phase == 1) ? rd : rc;
            if (!req || m_held >= TMO) begin
                if (req) begin
                    m_flag = 1'b1;
                    if (m_phase == 1) nrd = 1'b0; else nrc = 1'b0;
                end
                m_last       = m_phase;
                m_phase      = 3;
                m_guard_left = GUARD;
            end else begin
                m_held++;
            end
        end
        m_rearm_d = nrd;
        m_rearm_c = nrc;
    endtask

    task automatic check_all();
        logic gd, gc;
        logic [4:0] exp;
        gd = (m_phase == 1);
        gc = (m_phase == 2);
        exp = gd ? {dsp_cs_INV, dsp_clk, dsp_mosi, flash_miso, 1'b1} :
              gc ? {cpu_cs_INV, cpu_clk, cpu_mosi, 1'b1, flash_miso} : 5'b10011;
        chk("state", state, m_phase);
        chk("grant_dsp", grant_dsp, gd);
        chk("grant_cpu", grant_cpu, gc);
        chk("timeout_flag", timeout_flag, m_flag);
        chk("pins{cs,clk,mosi,dmiso,cmiso}",
            {flash_cs_INV, flash_clk, flash_mosi, dsp_miso, cpu_miso}, exp);
    endtask

    task automatic tick();
        @(posedge sysclk);
        model_edge();
        @(negedge sysclk);
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    // One byte from the DSP inside the low half-period while the CPU wiggles its own pins.
    task automatic dsp_byte(input logic [7:0] b, output logic [7:0] q, output int pulses);
        q = '0; pulses = 0;
        for (int i = 7; i >= 0; i--) begin
            dsp_mosi = b[i]; cpu_mosi = ~b[i];
            #4 dsp_clk = 1'b1; cpu_clk = ~cpu_clk;
            #1 q = {q[6:0], flash_mosi}; pulses += int'(flash_clk);
            #4 dsp_clk = 1'b0; cpu_clk = ~cpu_clk;
            #1;
        end
        dsp_mosi = 1'b0; cpu_mosi = 1'b0;
    endtask

    initial begin
        reset = 1'b1; dsp_bank_en = 1'b0; dsp_cs_INV = 1'b1; cpu_cs_INV = 1'b1;
        dsp_clk = 1'b0; dsp_mosi = 1'b0; cpu_clk = 1'b0; cpu_mosi = 1'b0; flash_miso = 1'b0;
        model_reset();
        #150;
        check_all();
        @(negedge sysclk);
        reset = 1'b0; dsp_bank_en = 1'b1;
        run(3);

        // Simultaneous request after reset: DSP first, 3rd edge latency.
        dsp_cs_INV = 1'b0; cpu_cs_INV = 1'b0; flash_miso = 1'b1;
        tick(); chk("lat_edge1", grant_dsp, 0);
        tick(); chk("lat_edge2", grant_dsp, 0);
        tick(); chk("tie1_dsp", grant_dsp, 1); chk("tie1_cpu", grant_cpu, 0);
        dsp_byte(8'hA5, got, cnt);
        chk("mosi_byte", got, 8'hA5);
        chk("sck_pulses", cnt, 8);
        chk("cpu_miso_blocked", cpu_miso, 1);
        run(2);
        dsp_cs_INV = 1'b1;
        #1 chk("cs_release_immediate", flash_cs_INV, 1);
        first = 0; seen = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (grant_cpu && first == 0) first = i;
            if (state == 2'd3) seen++;
        end
        chk("cpu_grant_edge", first, 8);
        chk("guard_len", seen, GUARD);
        cpu_cs_INV = 1'b1;
        run(10);
        dsp_cs_INV = 1'b0; cpu_cs_INV = 1'b0;
        run(3);
        chk("tie2_dsp", grant_dsp, 1);
        dsp_cs_INV = 1'b1; cpu_cs_INV = 1'b1;
        run(10);

        // Bank disabled: DSP ignored; bank drop during ownership releases without flag.
        dsp_bank_en = 1'b0; dsp_cs_INV = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin tick(); cnt += int'(grant_dsp); end
        chk("bank_off_ignored", cnt, 0);
        dsp_bank_en = 1'b1;
        first = 0;
        for (int i = 1; i <= 8; i++) begin tick(); if (grant_dsp && first == 0) first = i; end
        chk("bank_on_grant", first != 0, 1);
        dsp_bank_en = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin tick(); if (state == 2'd3) seen = 1; end
        chk("bank_drop_guard", seen, 1);
        chk("bank_drop_cs", flash_cs_INV, 1);
        chk("bank_drop_noflag", timeout_flag, 0);
        dsp_cs_INV = 1'b1; dsp_bank_en = 1'b1;
        run(12);

        // Hold timeout.
        dsp_cs_INV = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin tick(); cnt += int'(grant_dsp); end
        chk("own_cycles", cnt, TMO);
        chk("timeout_set", timeout_flag, 1);
        dsp_cs_INV = 1'b1;
        run(3);
        dsp_cs_INV = 1'b0;
        first = 0;
        for (int i = 1; i <= 8; i++) begin tick(); if (grant_dsp && first == 0) first = i; end
        chk("regrant_edge", first, 3);
        chk("flag_sticky", timeout_flag, 1);
        dsp_cs_INV = 1'b1;
        run(12);

        // Async reset in the middle of a CPU transfer.
        cpu_cs_INV = 1'b0;
        run(4);
        chk("cpu_owns", grant_cpu, 1);
        cpu_clk = 1'b1; cpu_mosi = 1'b1; flash_miso = 1'b0;
        @(posedge sysclk);
        #37 reset = 1'b1;
        #1 chk("async_rst_pins", {flash_cs_INV, flash_clk, flash_mosi, dsp_miso, cpu_miso}, 5'b10011);
        chk("async_rst_ctl", {state, grant_dsp, grant_cpu, timeout_flag}, 5'b0);
        model_reset();
        @(negedge sysclk);
        reset = 1'b0; cpu_clk = 1'b0; cpu_mosi = 1'b0;
        tick(); chk("post_rst_e1", grant_cpu, 0);
        tick(); chk("post_rst_e2", grant_cpu, 0);
        tick(); chk("post_rst_e3", grant_cpu, 1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            tick();
            if ($urandom_range(11) == 0) dsp_cs_INV = ~dsp_cs_INV;
            if ($urandom_range(11) == 0) cpu_cs_INV = ~cpu_cs_INV;
            if ($urandom_range(39) == 0) dsp_bank_en = ~dsp_bank_en;
            dsp_clk = 1'($urandom); dsp_mosi = 1'($urandom);
            cpu_clk = 1'($urandom); cpu_mosi = 1'($urandom);
            flash_miso = 1'($urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_flash_arbiter.md
Name: spi_flash_arbiter

Overview:
Shares the single board SPI flash between two masters: the DSP SPI port (chip select 0) and CPU SPI0. It is a registered arbiter on the internal oscillator clock. A master's chip-select-low is its request. The block muxes SCK, MOSI and CS to the flash for the current owner only, returns MISO to that owner, and enforces a guard gap between owners and a hold timeout. It replaces the fixed DSP-to-flash wiring in cpld_top.

Parameters:
GUARD_CYCLES, 4, sysclk cycles flash CS stays high between owners (range 1..15)
TIMEOUT_CYCLES, 1048576, max sysclk cycles one owner may hold CS low; 0 disables timeout
TMR_W, 21, timeout counter width; must hold TIMEOUT_CYCLES

Ports:
sysclk  in  1  free-running internal oscillator clock, 3.3-5.5 MHz
reset  in  1  asynchronous, active-high
dsp_bank_en  in  1  DSP I/O bank powered; when 0, DSP requests are ignored
dsp_cs_INV  in  1  DSP chip select, async to sysclk; low = request
dsp_clk  in  1  DSP SCK
dsp_mosi  in  1  DSP MOSI
dsp_miso  out  1  flash MISO to DSP
cpu_cs_INV  in  1  CPU chip select, async; low = request
cpu_clk  in  1  CPU SCK
cpu_mosi  in  1  CPU MOSI
cpu_miso  out  1  flash MISO to CPU
flash_cs_INV  out  1  flash chip select
flash_clk  out  1  flash SCK
flash_mosi  out  1  flash MOSI
flash_miso  in  1  flash MISO
grant_dsp  out  1  DSP owns flash (routed to a GPIO for master polling)
grant_cpu  out  1  CPU owns flash
timeout_flag  out  1  sticky; set on forced release, cleared only by reset
state  out  2  current state, for LED/debug

Behaviour:
- Reset (async, high): state IDLE; grants 0; timeout_flag 0; last_owner = CPU; guard and timeout counters 0; re-arm flags set.
- Outputs during reset: flash_cs_INV = 1, flash_clk = 0, flash_mosi = 0, both miso outputs = 1.
- Synchronisation: each CS passes through a 2-flop synchroniser. The synchronised request is req_x = ~cs_sync & rearm_x. For DSP it is also ANDed with dsp_bank_en.
- rearm_x clears on forced release. It sets again once the synchronised CS of that master is seen high.
- States:
  - IDLE = 0
  - OWN_DSP = 1
  - OWN_CPU = 2
  - GUARD = 3
- IDLE:
  - Only one request present: go to that owner.
  - Both requests present: grant the master that is not last_owner. After reset, DSP wins first.
  - No request: stay in IDLE.
- OWN_x:
  - grant_x = 1 (registered).
  - Timeout counter increments every cycle and is cleared on entry.
  - req_x low: go to GUARD and set last_owner = x.
  - Counter reaches TIMEOUT_CYCLES-1 (and TIMEOUT_CYCLES != 0): set timeout_flag, clear rearm_x, go to GUARD, set last_owner = x.
  - DSP owner with dsp_bank_en low: immediate GUARD, no timeout flag.
- GUARD:
  - Grants 0.
  - Counts GUARD_CYCLES, then goes to IDLE.
  - Requests arriving during GUARD are evaluated on the IDLE cycle.
- Datapath (combinational from the registered grant):
  - flash_cs_INV = grant_dsp ? dsp_cs_INV : grant_cpu ? cpu_cs_INV : 1.
  - flash_clk and flash_mosi use the same mux, with 0 when there is no grant.
  - The owner's miso = flash_miso; the non-owner's miso = 1.
- Latency: the grant rises on the 3rd rising sysclk edge after CS falls.
- Flash CS deasserts combinationally the moment the owner raises CS. Grant drop lags by 3 edges.
- Master protocol: a master must see its grant high before clocking. Edges issued before the grant do not reach the flash.
- Both grants are never high at once. flash_cs_INV is never low in IDLE or GUARD.

Decomposition:
- Shared package spi_arb_pkg:
  - state encoding constants (IDLE/OWN_DSP/OWN_CPU/GUARD)
  - owner encoding
  - default GUARD_CYCLES and TIMEOUT_CYCLES
- Sub-module sync2 (2-flop synchroniser with async reset). Reset values:
  - DSP/CPU CS synchroniser instances preset to 1 (CS idle)
  - dsp_bank_en instance reset to 0
- FSM, counters and mux stay in the top module.

Test Plan:
- DSP CS low alone → grant_dsp = 1 on 3rd edge. flash_cs_INV tracks dsp_cs_INV; 8 SCK pulses of 0xA5 on MOSI appear on flash_mosi; cpu_miso = 1; state = 1.
- Both CS fall on the same cycle → DSP granted first. DSP CS rises → flash_cs_INV = 1 immediately, GUARD for 4 cycles, then grant_cpu = 1; the next simultaneous request goes to DSP.
- CPU toggles CS/SCK during DSP ownership → flash pins show only DSP activity; cpu_miso = 1; grant_cpu stays 0.
- TIMEOUT_CYCLES = 16 and DSP holds CS low → forced release after 16 cycles with timeout_flag = 1. DSP is not re-granted while CS stays low; CS high then low → re-granted; flag stays 1.
- dsp_bank_en = 0 → DSP requests ignored. Dropping dsp_bank_en during DSP ownership → GUARD and flash_cs_INV = 1 with no flag.
- Assert reset mid-CPU transfer, off a clock edge → outputs go to reset values at once without a clock edge. After release, a held CPU request is granted 3 edges later.
